mux_scan_ctrl: RTL and testbench

Sequential select generator and result capture for the 4:1 mux stage. It sits directly upstream of the mux, driving its S1/S0 select lines. It also sits downstream of the mux, sampling its Y output. On a start request it visits each enabled channel in ascending order, holds each select for a programmable dwell so the mux output settles, and captures Y per channel into a 4-bit result register. It then pulses done.

---
 rtl/mux_scan_pkg.sv | 15 +
 rtl/mux_scan_next_ch.sv | 40 ++++
 rtl/mux_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg
//   Shared definitions for the 4:1 mux scan controller: channel count,
//   select width and the controller state encoding.
package mux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mux_scan_next_ch.sv
// mux_scan_next_ch
//   Combinational search for the next enabled channel.
//   Ports:
//     mask_i        channel enable mask
//     cur_i         current channel index
//     from_lowest_i 1: return the lowest enabled channel (ignore cur_i)
//                   0: return the lowest enabled channel strictly above cur_i
//     nxt_o         index found (0 when nothing is found)
//     found_o       1 when an enabled channel satisfies the search
module mux_scan_next_ch
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [SEL_W-1:0]  cur_i,
  input  logic              from_lowest_i,
  output logic [SEL_W-1:0]  nxt_o,
  output logic              found_o
);

  logic [NUM_CH-1:0] cand;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
      assign cand[gi] = mask_i[gi] & (from_lowest_i | (cur_i < SEL_W'(gi)));
    end
  endgenerate

  // Walk from the top down so the lowest candidate is the last one written.
  always_comb begin
    nxt_o   = '0;
    found_o = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        nxt_o   = SEL_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
//   Sequential select generator and result capture for a 4:1 mux.
//   On start it steps {S1,S0} through the enabled channels in ascending
//   order, holds each for DWELL cycles, captures Y at the end of each dwell
//   into sample[channel], then pulses done for one cycle.
//   Ports:
//     clk     rising-edge clock
//     rst_n   asynchronous active-low reset
//     start   scan request, sampled only while idle
//     ch_en   channel enable mask, latched when start is accepted
//     Y       mux output fed back
//     S1,S0   mux select lines
//     busy    high while scanning
//     done    one-cycle completion pulse
//     sample  per-channel captured Y values
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              Y,
  output logic              S1,
  output logic              S0,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] sample
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  state_e            state_q,  state_d;
  logic [CW-1:0]     cnt_q,    cnt_d;
  logic [NUM_CH-1:0] mask_q,   mask_d;
  logic [SEL_W-1:0]  sel_q,    sel_d;
  logic [NUM_CH-1:0] sample_q, sample_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;

  logic [SEL_W-1:0]  first_ch;
  logic              first_found;
  logic [SEL_W-1:0]  next_ch;
  logic              next_found;

  // First channel comes straight from the incoming mask so it can be driven
  // on the accepting edge.
  mux_scan_next_ch u_first (
    .mask_i        (ch_en),
    .cur_i         ('0),
    .from_lowest_i (1'b1),
    .nxt_o         (first_ch),
    .found_o       (first_found)
  );

  mux_scan_next_ch u_next (
    .mask_i        (mask_q),
    .cur_i         (sel_q),
    .from_lowest_i (1'b0),
    .nxt_o         (next_ch),
    .found_o       (next_found)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    sel_d    = sel_q;
    sample_d = sample_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sample_d = '0;
          if (first_found) begin
            mask_d  = ch_en;
            sel_d   = first_ch;
            cnt_d   = '0;
            state_d = SCAN;
          end else begin
            // Empty mask: complete immediately, select lines untouched.
            state_d = DONE;
          end
        end
      end
      SCAN: begin
        if (cnt_q == CNT_LAST) begin
          sample_d[sel_q] = Y;
          cnt_d           = '0;
          if (next_found) begin
            sel_d = next_ch;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered copies of the next state.
    busy_d = (state_d == SCAN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mask_q   <= '0;
      sel_q    <= '0;
      sample_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      sel_q    <= sel_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign S1     = sel_q[1];
  assign S0     = sel_q[0];
  assign busy   = busy_q;
  assign done   = done_q;
  assign sample = sample_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
module tb_mux_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] ch_en;
  logic       Y;
  logic       S1;
  logic       S0;
  logic       busy;
  logic       done;
  logic [3:0] sample;

  // Behavioural stand-in for the 4:1 mux: Y = I[{S1,S0}].
  logic [3:0] mux_in;
  assign Y = mux_in[{S1, S0}];

  int total = 0;
  int bad   = 0;

  mux_scan_ctrl #(.DWELL(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .ch_en  (ch_en),
    .Y      (Y),
    .S1     (S1),
    .S0     (S0),
    .busy   (busy),
    .done   (done),
    .sample (sample)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a scan and check every cycle up to the return to idle.
  // pulse_k >= 0 pulses start during SCAN cycle pulse_k and on the DONE cycle.
  task automatic run_scan(input string name, input logic [3:0] en,
                          input logic [3:0] exp_sample, input logic [1:0] s_before,
                          input int pulse_k);
    int k;
    start = 1'b1;
    ch_en = en;
    step();
    start = 1'b0;
    ch_en = 4'b0001;
    if (en == 4'b0000) begin
      chk({name, " done"}, {7'd0, done}, 8'd1);
      chk({name, " busy"}, {7'd0, busy}, 8'd0);
      chk({name, " sel"}, {6'd0, S1, S0}, {6'd0, s_before});
      chk({name, " sample"}, {4'd0, sample}, {4'd0, exp_sample});
    end else begin
      k = 0;
      for (int ch = 0; ch < 4; ch++) begin
        if (en[ch]) begin
          for (int d = 0; d < 4; d++) begin
            chk($sformatf("%s sel k%0d", name, k), {6'd0, S1, S0}, 8'(ch));
            chk($sformatf("%s busy k%0d", name, k), {7'd0, busy}, 8'd1);
            chk($sformatf("%s done k%0d", name, k), {7'd0, done}, 8'd0);
            start = (k == pulse_k);
            step();
            k++;
          end
        end
      end
      start = 1'b0;
      chk({name, " done pulse"}, {7'd0, done}, 8'd1);
      chk({name, " busy end"}, {7'd0, busy}, 8'd0);
      chk({name, " sample"}, {4'd0, sample}, {4'd0, exp_sample});
      chk({name, " sel hold"}, {6'd0, S1, S0}, {6'd0, s_before});
    end
    start = (pulse_k >= 0);
    step();
    start = 1'b0;
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("%s idle done %0d", name, j), {7'd0, done}, 8'd0);
      chk($sformatf("%s idle busy %0d", name, j), {7'd0, busy}, 8'd0);
      step();
    end
    $display("scan %s en=%b sample=%b", name, en, sample);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    ch_en  = 4'b0000;
    mux_in = 4'b1010;  // I0=0 I1=1 I2=0 I3=1

    // Reset state
    #2;
    chk("rst sel", {6'd0, S1, S0}, 8'd0);
    chk("rst busy", {7'd0, busy}, 8'd0);
    chk("rst done", {7'd0, done}, 8'd0);
    chk("rst sample", {4'd0, sample}, 8'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      chk($sformatf("quiet busy %0d", j), {7'd0, busy}, 8'd0);
      chk($sformatf("quiet done %0d", j), {7'd0, done}, 8'd0);
      chk($sformatf("quiet sel %0d", j), {6'd0, S1, S0}, 8'd0);
    end
    $display("reset checked");

    // Full scan
    run_scan("full", 4'b1111, 4'b1010, 2'b11, -1);

    // Single channel, I2=0 then I2=1
    run_scan("single0", 4'b0100, 4'b0000, 2'b10, -1);
    mux_in = 4'b1110;
    run_scan("single1", 4'b0100, 4'b0100, 2'b10, -1);
    mux_in = 4'b1010;

    // Empty mask: S keeps its last value (10)
    run_scan("empty", 4'b0000, 4'b0000, 2'b10, -1);

    // Sparse mask
    run_scan("sparse", 4'b1001, 4'b1000, 2'b11, -1);

    // Start pulsed mid-scan and on the DONE cycle must be ignored
    run_scan("ignore", 4'b1111, 4'b1010, 2'b11, 5);

    // Reset mid-scan
    start = 1'b1;
    ch_en = 4'b1111;
    step();
    start = 1'b0;
    for (int j = 0; j < 6; j++) step();
    rst_n = 1'b0;
    #1;
    chk("midrst sel", {6'd0, S1, S0}, 8'd0);
    chk("midrst busy", {7'd0, busy}, 8'd0);
    chk("midrst done", {7'd0, done}, 8'd0);
    chk("midrst sample", {4'd0, sample}, 8'd0);
    for (int j = 0; j < 3; j++) begin
      step();
      chk($sformatf("midrst hold done %0d", j), {7'd0, done}, 8'd0);
      chk($sformatf("midrst hold busy %0d", j), {7'd0, busy}, 8'd0);
    end
    rst_n = 1'b1;
    step();
    chk("post rst done", {7'd0, done}, 8'd0);
    $display("mid-scan reset checked");
    run_scan("after_rst", 4'b1111, 4'b1010, 2'b11, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
